// File: rtl/tensor_window_reader_if.sv
// Control, tensor_ram read port and output stream of the tensor window reader.
// The master modport is the reader's view. The slave modport is the host/consumer view.
interface tensor_window_reader_if #(
  parameter int D_WIDTH = 8,
  parameter int IMG_W   = 96,
  parameter int IMG_H   = 96,
  parameter int DEPTH   = IMG_W * IMG_H,
  parameter int AW      = $clog2(DEPTH),
  parameter int RW      = $clog2(IMG_H + 1),
  parameter int CW      = $clog2(IMG_W + 1)
);
  logic               start;
  logic [RW-1:0]      row0;
  logic [CW-1:0]      col0;
  logic [RW-1:0]      win_h;
  logic [CW-1:0]      win_w;
  logic               busy;
  logic               done;
  logic [AW-1:0]      ram_addr_r;
  logic [D_WIDTH-1:0] ram_dout;
  logic               out_valid;
  logic               out_ready;
  logic [D_WIDTH-1:0] out_data;
  logic               out_last_col;
  logic               out_last;

  modport master (
    input  start, row0, col0, win_h, win_w, ram_dout, out_ready,
    output busy, done, ram_addr_r, out_valid, out_data, out_last_col, out_last
  );

  modport slave (
    output start, row0, col0, win_h, win_w, ram_dout, out_ready,
    input  busy, done, ram_addr_r, out_valid, out_data, out_last_col, out_last
  );
endinterface

// File: rtl/tensor_window_reader.sv
// Streams a zero-padded rectangular window of a row-major tensor from tensor_ram
// onto a valid/ready stream, one element per cycle.
module tensor_window_reader #(
  parameter int D_WIDTH = 8,
  parameter int IMG_W   = 96,
  parameter int IMG_H   = 96,
  parameter int DEPTH   = IMG_W * IMG_H
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tensor_window_reader_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int CW = $clog2(IMG_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [RW-1:0]      row0_q, row0_d;
  logic [CW-1:0]      col0_q, col0_d;
  logic [RW-1:0]      win_h_q, win_h_d;
  logic [CW-1:0]      win_w_q, win_w_d;
  logic [RW-1:0]      r_q, r_d;
  logic [CW-1:0]      c_q, c_d;

  logic               inflight_q, inflight_d;
  logic               inflight_pad_q, inflight_pad_d;
  logic               inflight_last_col_q, inflight_last_col_d;
  logic               inflight_last_q, inflight_last_d;

  logic [D_WIDTH-1:0] fifo_data_q [2];
  logic [D_WIDTH-1:0] fifo_data_d [2];
  logic [1:0]         fifo_last_col_q, fifo_last_col_d;
  logic [1:0]         fifo_last_q, fifo_last_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         count_q, count_d;

  logic [31:0]        row_abs;
  logic [31:0]        col_abs;
  logic [AW-1:0]      pos_addr;
  logic               pos_pad;
  logic               pos_last_col;
  logic               pos_last_row;
  logic               pop;
  logic               push;
  logic [2:0]         occupancy;
  logic               issue;

  // Current window position; pad test is done on widened coordinates so nothing wraps.
  always_comb begin
    row_abs      = 32'(row0_q) + 32'(r_q);
    col_abs      = 32'(col0_q) + 32'(c_q);
    pos_addr     = AW'(row_abs * 32'(IMG_W) + col_abs);
    pos_pad      = (row_abs >= 32'(IMG_H)) || (col_abs >= 32'(IMG_W));
    pos_last_col = ({1'b0, c_q} + (CW+1)'(1)) == {1'b0, win_w_q};
    pos_last_row = ({1'b0, r_q} + (RW+1)'(1)) == {1'b0, win_h_q};
  end

  // A new position may only issue when the in-flight slot plus FIFO can still hold it.
  always_comb begin
    pop       = (count_q != 2'd0) && bus.out_ready;
    push      = inflight_q;
    occupancy = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    issue     = (state_q == RUN) && (occupancy < 3'd2);
  end

  always_comb begin
    state_d             = state_q;
    row0_d              = row0_q;
    col0_d              = col0_q;
    win_h_d             = win_h_q;
    win_w_d             = win_w_q;
    r_d                 = r_q;
    c_d                 = c_q;
    inflight_d          = issue;
    inflight_pad_d      = inflight_pad_q;
    inflight_last_col_d = inflight_last_col_q;
    inflight_last_d     = inflight_last_q;
    fifo_data_d         = fifo_data_q;
    fifo_last_col_d     = fifo_last_col_q;
    fifo_last_d         = fifo_last_q;
    rd_ptr_d            = rd_ptr_q;
    wr_ptr_d            = wr_ptr_q;
    count_d             = count_q + {1'b0, push} - {1'b0, pop};

    // The in-flight element always lands in the FIFO the cycle after its address.
    if (push) begin
      fifo_data_d[wr_ptr_q]     = inflight_pad_q ? '0 : bus.ram_dout;
      fifo_last_col_d[wr_ptr_q] = inflight_last_col_q;
      fifo_last_d[wr_ptr_q]     = inflight_last_q;
      wr_ptr_d                  = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          row0_d  = bus.row0;
          col0_d  = bus.col0;
          win_h_d = bus.win_h;
          win_w_d = bus.win_w;
          r_d     = '0;
          c_d     = '0;
          if ((bus.win_h == '0) || (bus.win_w == '0)) begin
            state_d = FINISH;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (issue) begin
          inflight_pad_d      = pos_pad;
          inflight_last_col_d = pos_last_col;
          inflight_last_d     = pos_last_col && pos_last_row;
          if (pos_last_col) begin
            c_d = '0;
            if (pos_last_row) begin
              state_d = DRAIN;
            end else begin
              r_d = r_q + RW'(1);
            end
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (count_d == 2'd0) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      row0_q              <= '0;
      col0_q              <= '0;
      win_h_q             <= '0;
      win_w_q             <= '0;
      r_q                 <= '0;
      c_q                 <= '0;
      inflight_q          <= 1'b0;
      inflight_pad_q      <= 1'b0;
      inflight_last_col_q <= 1'b0;
      inflight_last_q     <= 1'b0;
      fifo_data_q[0]      <= '0;
      fifo_data_q[1]      <= '0;
      fifo_last_col_q     <= '0;
      fifo_last_q         <= '0;
      rd_ptr_q            <= 1'b0;
      wr_ptr_q            <= 1'b0;
      count_q             <= '0;
    end else begin
      state_q             <= state_d;
      row0_q              <= row0_d;
      col0_q              <= col0_d;
      win_h_q             <= win_h_d;
      win_w_q             <= win_w_d;
      r_q                 <= r_d;
      c_q                 <= c_d;
      inflight_q          <= inflight_d;
      inflight_pad_q      <= inflight_pad_d;
      inflight_last_col_q <= inflight_last_col_d;
      inflight_last_q     <= inflight_last_d;
      fifo_data_q         <= fifo_data_d;
      fifo_last_col_q     <= fifo_last_col_d;
      fifo_last_q         <= fifo_last_d;
      rd_ptr_q            <= rd_ptr_d;
      wr_ptr_q            <= wr_ptr_d;
      count_q             <= count_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == FINISH);
  assign bus.ram_addr_r   = (state_q == RUN) ? pos_addr : '0;
  assign bus.out_valid    = (count_q != 2'd0);
  assign bus.out_data     = bus.out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.out_last_col = bus.out_valid && fifo_last_col_q[rd_ptr_q];
  assign bus.out_last     = bus.out_valid && fifo_last_q[rd_ptr_q];

endmodule
